// File: rtl/hi_pkg.sv
// hi_pkg: definitions shared by the host-interface endpoints.
//   - host opcode encodings
//   - endpoint addresses for the read pipe's data and status endpoints
//   - status register indices, flag bit positions and control bit positions
package hi_pkg;

  typedef enum logic [3:0] {
    SETEP   = 4'h1,
    SETREG  = 4'h2,
    SETRVAL = 4'h3,
    RDDATA  = 4'h4,
    GETRVAL = 4'h5,
    RDTC    = 4'h6,
    WRDATA  = 4'h7
  } hi_opcode_e;

  localparam logic [15:0] EP_DATA = 16'h0010;
  localparam logic [15:0] EP_STAT = 16'h0011;

  localparam logic [15:0] REG_COUNT = 16'd0;
  localparam logic [15:0] REG_FLAGS = 16'd1;
  localparam logic [15:0] REG_DROP  = 16'd2;
  localparam logic [15:0] REG_RDLO  = 16'd3;
  localparam logic [15:0] REG_RDHI  = 16'd4;

  // Bit positions within the flags register (read side)
  localparam int FLAG_EMPTY = 0;
  localparam int FLAG_FULL  = 1;
  localparam int FLAG_OVF   = 2;

  // Bit positions within the flags register (write side)
  localparam int CTL_FLUSH = 0;
  localparam int CTL_CLEAR = 2;

endpackage

// File: rtl/di_fifo_ram.sv
// di_fifo_ram: simple dual-port 2^AW x 16 RAM. It has one write port and one
// read port. The read port is synchronous: rdata holds mem[raddr] as sampled
// at the previous edge, and the read returns the old contents when the same
// address is written in that cycle. There is no reset, so the RAM maps onto
// block RAM.
// Ports:
//   if_clock     clock
//   we/waddr/wdata  write port
//   raddr/rdata     registered read port
module di_fifo_ram #(
  parameter int AW = 9
) (
  input  logic          if_clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  import hi_pkg::*;

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge if_clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/di_read_pipe.sv
// di_read_pipe: device-interface endpoint that serves producer words to the
// host through a first-word-fall-through FIFO. A second endpoint exposes the
// status and control registers.
// Ports:
//   if_clock, resetb          clock, async active-low reset
//   diEpAddr/diRegAddr        endpoint select / status register index
//   diRegDataIn/diWrite       status register writes (flush, clear overflow)
//   diRead                    pop strobe on the data endpoint
//   diReset                   synchronous flush
//   diRegDataOut              head word or status data; 0 when the block is not selected
//   rd_ready                  a pop is allowed on the next cycle
//   wr_ready                  constant 1
//   prod_we/prod_data         producer push (the producer cannot stall)
//   fifo_full, overflow       throttle hint, sticky dropped-word flag
module di_read_pipe #(
  parameter logic [15:0] EP_DATA = hi_pkg::EP_DATA,
  parameter logic [15:0] EP_STAT = hi_pkg::EP_STAT,
  parameter int          AW      = 9
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic [15:0] diEpAddr,
  input  logic [15:0] diRegAddr,
  input  logic [15:0] diRegDataIn,
  input  logic        diWrite,
  input  logic        diRead,
  input  logic        diReset,
  output logic [15:0] diRegDataOut,
  output logic        rd_ready,
  output logic        wr_ready,
  input  logic        prod_we,
  input  logic [15:0] prod_data,
  output logic        fifo_full,
  output logic        overflow
);
  import hi_pkg::*;

  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW-1:0] ram_raddr;
  logic [AW:0]   count;
  logic [15:0]   ram_rdata;
  logic [15:0]   head_reg;
  logic          head_bypass;
  logic [15:0]   head_word;
  logic [15:0]   drop_cnt;
  logic [31:0]   rd_total;
  logic          overflow_q;
  logic [15:0]   stat_data;

  logic sel_d;
  logic sel_s;
  logic stat_wr;
  logic flush;
  logic clear_ovf;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic bypass_load;

  assign sel_d = (diEpAddr == EP_DATA);
  assign sel_s = (diEpAddr == EP_STAT);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign stat_wr   = sel_s && diWrite && (diRegAddr == REG_FLAGS);
  assign flush     = diReset || (stat_wr && diRegDataIn[CTL_FLUSH]);
  assign clear_ovf = stat_wr && diRegDataIn[CTL_CLEAR];

  // A flush discards everything, so a pop in that cycle does not count toward
  // rd_total. A push in that cycle is dropped silently.
  assign pop  = sel_d && diRead && !empty && !flush;
  assign push = prod_we && !flush && (!full || pop);
  assign drop = prod_we && !flush && full && !pop;

  assign rd_ptr_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign ram_raddr   = flush ? '0 : rd_ptr_next;

  // The RAM read is always aimed at the next head address. A pushed word that
  // becomes the head at this same edge cannot come back from the RAM in time,
  // so it is also captured in head_reg and presented from there for one cycle.
  assign bypass_load = push && (empty || (count == CNT_ONE && pop));
  assign head_word   = head_bypass ? head_reg : ram_rdata;

  di_fifo_ram #(
    .AW(AW)
  ) u_ram (
    .if_clock(if_clock),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata   (prod_data),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_next;
      count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      head_bypass <= 1'b0;
      head_reg    <= '0;
    end else if (flush) begin
      head_bypass <= 1'b0;
    end else if (bypass_load) begin
      head_bypass <= 1'b1;
      head_reg    <= prod_data;
    end else begin
      head_bypass <= 1'b0;
    end
  end

  // When a clear and a drop occur in the same cycle, the clear is applied
  // first and the new drop is then recorded.
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
      rd_total   <= '0;
    end else begin
      if (clear_ovf) begin
        overflow_q <= drop;
        drop_cnt   <= {15'd0, drop};
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (pop) rd_total <= rd_total + 32'd1;
    end
  end

  always_comb begin
    stat_data = '0;
    case (diRegAddr)
      REG_COUNT: stat_data = 16'(count);
      REG_FLAGS: begin
        stat_data[FLAG_EMPTY] = empty;
        stat_data[FLAG_FULL]  = full;
        stat_data[FLAG_OVF]   = overflow_q;
      end
      REG_DROP:  stat_data = drop_cnt;
      REG_RDLO:  stat_data = rd_total[15:0];
      REG_RDHI:  stat_data = rd_total[31:16];
      default:   stat_data = '0;
    endcase
  end

  // Zero when the block is not selected, so several endpoints can share an OR bus
  always_comb begin
    diRegDataOut = '0;
    if (sel_d) begin
      if (!empty) diRegDataOut = head_word;
    end else if (sel_s) begin
      diRegDataOut = stat_data;
    end
  end

  // Drops in the cycle that pops the last word, so a strobe on the next edge cannot underflow
  assign rd_ready  = sel_d && ((count > CNT_ONE) || (count == CNT_ONE && !pop));
  assign wr_ready  = 1'b1;
  assign fifo_full = full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_di_read_pipe.sv
// tb_di_read_pipe: self-checking bench for di_read_pipe with AW=4.
// A queue-based reference model holds the FIFO contents, the drop and read
// totals and the overflow flag. Every cycle, the bench compares rd_ready,
// fifo_full, overflow and the read data against that model. Directed steps
// cover fill/drain, overflow, push while full, random wrap-around, flush,
// deselect and async reset.
module tb_di_read_pipe;
  import hi_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] EP_NONE = 16'h0020;

  logic        if_clock = 1'b0;
  logic        resetb;
  logic [15:0] diEpAddr;
  logic [15:0] diRegAddr;
  logic [15:0] diRegDataIn;
  logic        diWrite;
  logic        diRead;
  logic        diReset;
  logic [15:0] diRegDataOut;
  logic        rd_ready;
  logic        wr_ready;
  logic        prod_we;
  logic [15:0] prod_data;
  logic        fifo_full;
  logic        overflow;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  // Reference model
  logic [15:0] modelQ[$];
  int          modelT[$];
  int          modelDrop = 0;
  logic        modelOvf  = 1'b0;
  logic [31:0] modelTotal = '0;

  always #5 if_clock = ~if_clock;

  di_read_pipe #(
    .EP_DATA(EP_DATA),
    .EP_STAT(EP_STAT),
    .AW     (AW)
  ) dut (
    .if_clock    (if_clock),
    .resetb      (resetb),
    .diEpAddr    (diEpAddr),
    .diRegAddr   (diRegAddr),
    .diRegDataIn (diRegDataIn),
    .diWrite     (diWrite),
    .diRead      (diRead),
    .diReset     (diReset),
    .diRegDataOut(diRegDataOut),
    .rd_ready    (rd_ready),
    .wr_ready    (wr_ready),
    .prod_we     (prod_we),
    .prod_data   (prod_data),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] statusValue(input logic [15:0] ra);
    int sz;
    sz = modelQ.size();
    case (ra)
      16'd0:   return 16'(sz);
      16'd1:   return {13'd0, modelOvf, (sz == DEPTH), (sz == 0)};
      16'd2:   return 16'(modelDrop);
      16'd3:   return modelTotal[15:0];
      16'd4:   return modelTotal[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  // One clock cycle: drive the inputs, check the combinational outputs against
  // the model, take the edge, then advance the model.
  task automatic applyStimulus(input logic [15:0] ep, input logic [15:0] ra, input logic [15:0] wd,
                               input logic wr, input logic rd, input logic rst,
                               input logic pwe, input logic [15:0] pd);
    int   sz;
    logic flushE, popE, clrE, acceptE, dropE, rdyE;
    diEpAddr = ep; diRegAddr = ra; diRegDataIn = wd; diWrite = wr;
    diRead = rd; diReset = rst; prod_we = pwe; prod_data = pd;
    #1;
    sz      = modelQ.size();
    flushE  = rst || (ep == EP_STAT && wr && ra == 16'd1 && wd[0]);
    clrE    = (ep == EP_STAT && wr && ra == 16'd1 && wd[2]);
    popE    = (ep == EP_DATA) && rd && (sz != 0) && !flushE;
    acceptE = pwe && !flushE && ((sz < DEPTH) || popE);
    dropE   = pwe && !flushE && !acceptE;
    rdyE    = (ep == EP_DATA) && ((sz > 1) || (sz == 1 && !popE));
    checkOutput("rd_ready", {31'd0, rd_ready}, {31'd0, rdyE});
    checkOutput("fifo_full", {31'd0, fifo_full}, {31'd0, (sz == DEPTH)});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, modelOvf});
    if (ep == EP_DATA && sz != 0 && cyc >= modelT[0] + 1)
      checkOutput("head_word", {16'd0, diRegDataOut}, {16'd0, modelQ[0]});
    else if (ep == EP_STAT)
      checkOutput("status_read", {16'd0, diRegDataOut}, {16'd0, statusValue(ra)});
    else if (ep != EP_DATA)
      checkOutput("deselect_data", {16'd0, diRegDataOut}, 32'd0);
    @(posedge if_clock);
    cyc++;
    if (popE) begin
      void'(modelQ.pop_front());
      void'(modelT.pop_front());
      modelTotal++;
    end
    if (flushE) begin
      modelQ.delete();
      modelT.delete();
    end
    if (acceptE) begin
      modelQ.push_back(pd);
      modelT.push_back(cyc);
    end
    if (clrE) begin
      modelOvf  = dropE;
      modelDrop = dropE ? 1 : 0;
    end else if (dropE) begin
      modelOvf = 1'b1;
      if (modelDrop < 65535) modelDrop++;
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(EP_NONE, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic pushWord(input logic [15:0] d);
    applyStimulus(EP_NONE, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic readWord();
    applyStimulus(EP_DATA, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  // Reads a status register between edges without advancing the clock
  task automatic readReg(input string tag, input logic [15:0] ra, input logic [15:0] expected);
    diEpAddr = EP_STAT; diRegAddr = ra; diWrite = 1'b0; diRead = 1'b0;
    diReset = 1'b0; prod_we = 1'b0;
    #1;
    checkOutput(tag, {16'd0, diRegDataOut}, {16'd0, expected});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pushed;
    int iter;
    logic rdSel, pweSel;
    logic [31:0] totalBeforeFlush;

    resetb = 1'b0;
    diEpAddr = EP_DATA; diRegAddr = '0; diRegDataIn = '0; diWrite = 1'b0;
    diRead = 1'b0; diReset = 1'b0; prod_we = 1'b0; prod_data = '0;
    #2;
    $display("[TB] reset state");
    checkOutput("reset_data", {16'd0, diRegDataOut}, 32'd0);
    checkOutput("reset_rd_ready", {31'd0, rd_ready}, 32'd0);
    checkOutput("reset_fifo_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    readReg("reset_count", REG_COUNT, 16'h0000);
    readReg("reset_flags", REG_FLAGS, 16'h0001);
    #5 resetb = 1'b1;
    @(posedge if_clock);
    #1;

    $display("[TB] fill and drain");
    for (int i = 0; i < 5; i++) pushWord(16'h1000 + 16'(i));
    readReg("fill_count", REG_COUNT, 16'd5);
    for (int i = 0; i < 5; i++) begin
      diEpAddr = EP_DATA; diRead = 1'b1;
      #1;
      checkOutput("drain_seq", {16'd0, diRegDataOut}, {16'd0, 16'h1000 + 16'(i)});
      readWord();
    end
    readWord();
    readReg("drain_count", REG_COUNT, 16'd0);
    readReg("drain_total", REG_RDLO, 16'd5);

    $display("[TB] overflow");
    for (int i = 0; i < 16; i++) pushWord(16'h2000 + 16'(i));
    readReg("full_flags", REG_FLAGS, 16'h0002);
    pushWord(16'h2010);
    readReg("ovf_flags", REG_FLAGS, 16'h0006);
    readReg("ovf_drop", REG_DROP, 16'd1);
    applyStimulus(EP_STAT, REG_FLAGS, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(EP_STAT, REG_FLAGS, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    readReg("clr_drop", REG_DROP, 16'd0);
    readReg("clr_flags", REG_FLAGS, 16'h0002);

    $display("[TB] push and pop while full");
    applyStimulus(EP_DATA, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    readReg("fullpp_count", REG_COUNT, 16'd16);
    readReg("fullpp_flags", REG_FLAGS, 16'h0002);
    for (int i = 0; i < 16; i++) begin
      diEpAddr = EP_DATA; diRead = 1'b1;
      #1;
      if (i == 15) checkOutput("beef_last", {16'd0, diRegDataOut}, 32'h0000BEEF);
      readWord();
    end
    readReg("fullpp_empty", REG_FLAGS, 16'h0001);

    $display("[TB] wrap-around stream");
    pushed = 0;
    iter = 0;
    while (pushed < 100 && iter < 2000) begin
      rdSel  = 1'($urandom_range(0, 1));
      pweSel = 1'($urandom_range(0, 1)) &&
               ((modelQ.size() < DEPTH) || (rdSel && modelQ.size() != 0));
      applyStimulus(EP_DATA, 16'd0, 16'd0, 1'b0, rdSel, 1'b0, pweSel, 16'($urandom));
      if (pweSel) pushed++;
      if (iter % 10 == 0) readReg("wrap_count", REG_COUNT, 16'(modelQ.size()));
      iter++;
    end
    checkOutput("wrap_pushed", pushed, 100);
    iter = 0;
    while (modelQ.size() != 0 && iter < 40) begin
      readWord();
      iter++;
    end
    readReg("wrap_empty", REG_FLAGS, 16'h0001);

    $display("[TB] flush");
    for (int i = 0; i < 7; i++) pushWord(16'h5000 + 16'(i));
    readReg("preflush_count", REG_COUNT, 16'd7);
    totalBeforeFlush = modelTotal;
    applyStimulus(EP_DATA, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7777);
    readReg("flush_count", REG_COUNT, 16'd0);
    readReg("flush_flags", REG_FLAGS, 16'h0001);
    readReg("flush_total", REG_RDLO, totalBeforeFlush[15:0]);
    diEpAddr = EP_DATA;
    #1;
    checkOutput("flush_rd_ready", {31'd0, rd_ready}, 32'd0);
    pushWord(16'h0042);
    idleCycle();
    diEpAddr = EP_DATA; diRead = 1'b1;
    #1;
    checkOutput("flush_first", {16'd0, diRegDataOut}, 32'h00000042);
    readWord();

    $display("[TB] deselect and async reset");
    for (int i = 0; i < 3; i++) pushWord(16'h6000 + 16'(i));
    diEpAddr = EP_NONE; diRead = 1'b1;
    #1;
    checkOutput("desel_data", {16'd0, diRegDataOut}, 32'd0);
    checkOutput("desel_rd_ready", {31'd0, rd_ready}, 32'd0);
    readWord();
    diEpAddr = EP_DATA; diRead = 1'b1; prod_we = 1'b1; prod_data = 16'h6666;
    #2;
    resetb = 1'b0;
    #1;
    modelQ.delete(); modelT.delete();
    modelDrop = 0; modelOvf = 1'b0; modelTotal = '0;
    checkOutput("areset_data", {16'd0, diRegDataOut}, 32'd0);
    checkOutput("areset_rd_ready", {31'd0, rd_ready}, 32'd0);
    checkOutput("areset_fifo_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("areset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("areset_wr_ready", {31'd0, wr_ready}, 32'd1);
    readReg("areset_total", REG_RDLO, 16'd0);
    diEpAddr = EP_NONE; diRead = 1'b0; prod_we = 1'b0;
    #1;
    resetb = 1'b1;
    @(posedge if_clock);
    cyc++;
    #1;
    pushWord(16'h0077);
    idleCycle();
    readWord();
    readReg("post_reset_total", REG_RDLO, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
